// File: rtl/fp_divsqrt_pkg.sv
// Shared types and default widths for the div/sqrt response buffering slice.
package fp_divsqrt_pkg;

    localparam int unsigned ID_WIDTH_DEF        = 9;
    localparam int unsigned DATA_WIDTH_DEF      = 32;
    localparam int unsigned FLAGS_OUT_WIDTH_DEF = 5;
    localparam int unsigned DEPTH_DEF           = 2;

    typedef struct packed {
        logic [DATA_WIDTH_DEF-1:0]      rdata;
        logic [FLAGS_OUT_WIDTH_DEF-1:0] rflags;
        logic [ID_WIDTH_DEF-1:0]        rID;
    } resp_t;

    typedef enum logic [1:0] {
        CREDIT_HOLD,
        CREDIT_TAKE,
        CREDIT_RETURN
    } credit_op_e;

endpackage

// File: rtl/fp_divsqrt_resp_mem.sv
// Response storage ring: slots, wrapping pointers and occupancy-derived full/empty.
module fp_divsqrt_resp_mem
    import fp_divsqrt_pkg::*;
#(
    parameter int unsigned WIDTH = DATA_WIDTH_DEF + FLAGS_OUT_WIDTH_DEF + ID_WIDTH_DEF,
    parameter int unsigned DEPTH = DEPTH_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] rdata
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] slots [DEPTH];
    logic [AW-1:0]    wptr;
    logic [AW-1:0]    rptr;
    logic [AW:0]      count;
    logic             write;
    logic             take;

    assign full  = (count == (AW+1)'(DEPTH));
    assign empty = (count == '0);
    // A push into a full ring only lands when the head leaves in the same cycle.
    assign write = push & (~full | pop);
    assign take  = pop & ~empty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (write) wptr <= wptr + AW'(1);
            if (take)  rptr <= rptr + AW'(1);
            if (write && !take)      count <= count + (AW+1)'(1);
            else if (take && !write) count <= count - (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (write) slots[wptr] <= wdata;
    end

    assign rdata = empty ? '0 : slots[rptr];

endmodule

// File: rtl/fp_divsqrt_resp_fifo.sv
// Credit-gated request path to the div/sqrt unit with in-order buffering of its results.
module fp_divsqrt_resp_fifo
    import fp_divsqrt_pkg::*;
#(
    parameter int unsigned ID_WIDTH        = ID_WIDTH_DEF,
    parameter int unsigned DATA_WIDTH      = DATA_WIDTH_DEF,
    parameter int unsigned FLAGS_OUT_WIDTH = FLAGS_OUT_WIDTH_DEF,
    parameter int unsigned DEPTH           = DEPTH_DEF
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       core_req_i,
    output logic                       core_gnt_o,
    output logic                       unit_req_o,
    input  logic                       unit_gnt_i,
    input  logic                       unit_rvalid_i,
    input  logic [DATA_WIDTH-1:0]      unit_rdata_i,
    input  logic [FLAGS_OUT_WIDTH-1:0] unit_rflags_i,
    input  logic [ID_WIDTH-1:0]        unit_rID_i,
    output logic                       core_rvalid_o,
    input  logic                       core_rready_i,
    output logic [DATA_WIDTH-1:0]      core_rdata_o,
    output logic [FLAGS_OUT_WIDTH-1:0] core_rflags_o,
    output logic [ID_WIDTH-1:0]        core_rID_o,
    output logic [$clog2(DEPTH):0]     credits_o,
    output logic                       overflow_o
);

    localparam int unsigned CW = $clog2(DEPTH) + 1;
    localparam int unsigned EW = DATA_WIDTH + FLAGS_OUT_WIDTH + ID_WIDTH;

    logic [CW-1:0] credits;
    logic          has_credit;
    logic          accept;
    logic          pop;
    logic          full;
    logic          empty;
    logic [EW-1:0] head;
    credit_op_e    credit_op;

    assign has_credit = (credits != '0);
    assign unit_req_o = core_req_i & has_credit;
    assign core_gnt_o = unit_gnt_i & has_credit;
    assign accept     = core_req_i & core_gnt_o;
    assign pop        = core_rvalid_o & core_rready_i;

    always_comb begin
        credit_op = CREDIT_HOLD;
        if (accept && !pop)      credit_op = CREDIT_TAKE;
        else if (pop && !accept) credit_op = CREDIT_RETURN;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            credits    <= CW'(DEPTH);
            overflow_o <= 1'b0;
        end else begin
            case (credit_op)
                CREDIT_TAKE:   credits <= credits - CW'(1);
                CREDIT_RETURN: credits <= credits + CW'(1);
                default:       credits <= credits;
            endcase
            if (unit_rvalid_i && full && !pop) overflow_o <= 1'b1;
        end
    end

    fp_divsqrt_resp_mem #(
        .WIDTH (EW),
        .DEPTH (DEPTH)
    ) u_mem (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (unit_rvalid_i),
        .pop   (pop),
        .wdata ({unit_rdata_i, unit_rflags_i, unit_rID_i}),
        .full  (full),
        .empty (empty),
        .rdata (head)
    );

    assign core_rvalid_o = ~empty;
    assign credits_o     = credits;
    assign {core_rdata_o, core_rflags_o, core_rID_o} = head;

endmodule

// File: tb/tb_fp_divsqrt_resp_fifo.sv
// Directed and randomized checks of the response FIFO against a queue-based reference model.
module tb_fp_divsqrt_resp_fifo;
    import fp_divsqrt_pkg::*;

    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        core_req_i, core_gnt_o, unit_req_o, unit_gnt_i;
    logic        unit_rvalid_i, core_rvalid_o, core_rready_i, overflow_o;
    logic [31:0] unit_rdata_i, core_rdata_o;
    logic [4:0]  unit_rflags_i, core_rflags_o;
    logic [8:0]  unit_rID_i, core_rID_o;
    logic [1:0]  credits_o;

    fp_divsqrt_resp_fifo #(
        .ID_WIDTH        (9),
        .DATA_WIDTH      (32),
        .FLAGS_OUT_WIDTH (5),
        .DEPTH           (DEPTH)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .core_req_i    (core_req_i),
        .core_gnt_o    (core_gnt_o),
        .unit_req_o    (unit_req_o),
        .unit_gnt_i    (unit_gnt_i),
        .unit_rvalid_i (unit_rvalid_i),
        .unit_rdata_i  (unit_rdata_i),
        .unit_rflags_i (unit_rflags_i),
        .unit_rID_i    (unit_rID_i),
        .core_rvalid_o (core_rvalid_o),
        .core_rready_i (core_rready_i),
        .core_rdata_o  (core_rdata_o),
        .core_rflags_o (core_rflags_o),
        .core_rID_o    (core_rID_o),
        .credits_o     (credits_o),
        .overflow_o    (overflow_o)
    );

    always #5 clk = ~clk;

    // Reference model: ops issued to the unit, buffered responses, credit count.
    resp_t pend[$];
    resp_t fq[$];
    int    m_credits;
    bit    m_ovf;
    bit    m_proto_ok;
    int    n_checks = 0;
    int    n_fail   = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic resp_t rnd_resp();
        resp_t r;
        r.rdata  = $urandom;
        r.rflags = 5'($urandom);
        r.rID    = 9'($urandom);
        return r;
    endfunction

    // ret_mode: 0 none, 1 oldest in-flight, 2 random in-flight, 3 unsolicited (new_e)
    task automatic cycle(input logic req, input logic gnt, input logic rdy,
                         input int ret_mode, input resp_t new_e);
        resp_t r;
        int    idx;
        logic  ret, hc, acc, pop;
        r   = '0;
        idx = -1;
        ret = 1'b0;
        @(negedge clk);
        core_req_i    = req;
        unit_gnt_i    = gnt;
        core_rready_i = rdy;
        if (ret_mode == 1 && pend.size() > 0) begin
            idx = 0; r = pend[0]; ret = 1'b1;
        end else if (ret_mode == 2 && pend.size() > 0) begin
            idx = $urandom_range(pend.size() - 1); r = pend[idx]; ret = 1'b1;
        end else if (ret_mode == 3) begin
            r = new_e; ret = 1'b1; m_proto_ok = 1'b0;
        end
        unit_rvalid_i = ret;
        unit_rdata_i  = r.rdata;
        unit_rflags_i = r.rflags;
        unit_rID_i    = r.rID;
        #1;
        hc = (m_credits != 0);
        chk("unit_req", unit_req_o, req & hc);
        chk("core_gnt", core_gnt_o, gnt & hc);
        chk("credits", credits_o, m_credits);
        chk("rvalid", core_rvalid_o, fq.size() != 0);
        chk("overflow", overflow_o, m_ovf);
        if (fq.size() != 0) begin
            chk("head_rdata", core_rdata_o, fq[0].rdata);
            chk("head_rflags", core_rflags_o, fq[0].rflags);
            chk("head_rID", core_rID_o, fq[0].rID);
        end
        if (m_proto_ok)
            chk("invariant", credits_o + pend.size() + fq.size(), DEPTH);
        acc = req & gnt & hc;
        pop = (fq.size() != 0) & rdy;
        @(posedge clk);
        if (ret && idx >= 0) pend.delete(idx);
        if (pop) void'(fq.pop_front());
        if (ret) begin
            if (fq.size() < DEPTH) fq.push_back(r);
            else m_ovf = 1'b1;
        end
        if (acc && !pop) m_credits--;
        else if (pop && !acc) m_credits++;
        if (acc) pend.push_back(new_e);
    endtask

    task automatic do_reset();
        @(negedge clk);
        core_req_i    = 1'b1;
        unit_gnt_i    = 1'b1;
        unit_rvalid_i = 1'b0;
        core_rready_i = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("rst_rvalid", core_rvalid_o, 1'b0);
        chk("rst_credits", credits_o, DEPTH);
        chk("rst_overflow", overflow_o, 1'b0);
        chk("rst_head", {core_rdata_o, core_rflags_o, core_rID_o}, '0);
        chk("rst_unit_req", unit_req_o, 1'b1);
        chk("rst_core_gnt", core_gnt_o, 1'b1);
        pend.delete();
        fq.delete();
        m_credits  = DEPTH;
        m_ovf      = 1'b0;
        m_proto_ok = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n      = 1'b1;
        core_req_i = 1'b0;
        unit_gnt_i = 1'b0;
    endtask

    initial begin
        resp_t e5, e6, x;
        rst_n = 1'b0;
        core_req_i = 1'b0; unit_gnt_i = 1'b0; unit_rvalid_i = 1'b0; core_rready_i = 1'b0;
        unit_rdata_i = '0; unit_rflags_i = '0; unit_rID_i = '0;
        e5 = '{rdata: 32'h3F80_0000, rflags: 5'h00, rID: 9'd5};
        e6 = '{rdata: 32'h4000_0000, rflags: 5'h01, rID: 9'd6};
        x  = '0;

        do_reset();
        cycle(0, 0, 0, 0, x);

        // Credit exhaustion: third request stalls.
        cycle(1, 1, 0, 0, e5);
        cycle(1, 1, 0, 0, e6);
        cycle(1, 1, 0, 0, rnd_resp());
        chk("credits_exhausted", credits_o, 2'd0);
        chk("unit_req_stalled", unit_req_o, 1'b0);

        // In-order return and drain.
        cycle(0, 0, 0, 1, x);
        cycle(0, 0, 0, 1, x);
        cycle(0, 0, 1, 0, x);
        cycle(0, 0, 1, 0, x);
        cycle(0, 0, 0, 0, x);

        // Accept and pop together at one credit.
        cycle(1, 1, 0, 0, rnd_resp());
        cycle(0, 0, 0, 1, x);
        cycle(1, 1, 1, 0, rnd_resp());
        cycle(0, 0, 0, 0, x);

        // Full FIFO, simultaneous push and pop.
        cycle(1, 1, 0, 0, rnd_resp());
        cycle(0, 0, 0, 1, x);
        cycle(0, 0, 0, 1, x);
        cycle(0, 0, 1, 3, rnd_resp());
        cycle(0, 0, 0, 0, x);

        // Push into full FIFO without pop: dropped, overflow sticks.
        cycle(0, 0, 0, 3, rnd_resp());
        cycle(0, 0, 0, 0, x);
        cycle(0, 0, 1, 0, x);
        cycle(0, 0, 1, 0, x);
        cycle(0, 0, 0, 0, x);

        do_reset();
        for (int i = 0; i < 400; i++)
            cycle(1'($urandom), 1'($urandom), 1'($urandom_range(3) != 0),
                  ($urandom_range(1) != 0) ? 2 : 0, rnd_resp());

        // Asynchronous reset with two entries buffered.
        do_reset();
        cycle(1, 1, 0, 0, rnd_resp());
        cycle(1, 1, 0, 0, rnd_resp());
        cycle(0, 0, 0, 2, x);
        cycle(0, 0, 0, 2, x);
        chk("buffered_before_reset", core_rvalid_o, 1'b1);
        do_reset();
        for (int i = 0; i < 50; i++)
            cycle(1'($urandom), 1'($urandom), 1'($urandom), 2, rnd_resp());

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fp_divsqrt_resp_fifo.md
FP_DIVSQRT_RESP_FIFO -- requirements
Module: fp_divsqrt_resp_fifo

Interface
REQ-001 Parameter ID_WIDTH, 9, width of transaction ID.
REQ-002 Parameter DATA_WIDTH, 32, result width.
REQ-003 Parameter FLAGS_OUT_WIDTH, 5, IEEE exception flag width.
REQ-004 Parameter DEPTH, 2, response slots and credits; power of two, >=2.
REQ-005 clk  in  1  clock, all logic on rising edge.
REQ-006 rst_n  in  1  reset, asynchronous, active-low.
REQ-007 core_req_i  in  1  upstream div/sqrt request.
REQ-008 core_gnt_o  out  1  request accepted this cycle.
REQ-009 unit_req_o  out  1  request forwarded to the div/sqrt unit.
REQ-010 unit_gnt_i  in  1  div/sqrt unit grant.
REQ-011 unit_rvalid_i  in  1  unit result pulse; carries no backpressure.
REQ-012 unit_rdata_i  in  DATA_WIDTH  unit result.
REQ-013 unit_rflags_i  in  FLAGS_OUT_WIDTH  unit flags.
REQ-014 unit_rID_i  in  ID_WIDTH  unit result ID.
REQ-015 core_rvalid_o  out  1  buffered response available.
REQ-016 core_rready_i  in  1  consumer accepts response.
REQ-017 core_rdata_o / core_rflags_o / core_rID_o  out  DATA_WIDTH / FLAGS_OUT_WIDTH / ID_WIDTH  head-entry fields.
REQ-018 credits_o  out  clog2(DEPTH)+1  free credits.
REQ-019 overflow_o  out  1  sticky protocol error.

Function
REQ-020 The block SHALL hold a credit counter initialised to DEPTH; has_credit = (credits != 0).
REQ-021 unit_req_o SHALL equal core_req_i & has_credit, and core_gnt_o SHALL equal unit_gnt_i & has_credit (both combinational).
REQ-022 Accept = core_req_i & core_gnt_o; pop = core_rvalid_o & core_rready_i.
REQ-023 Credits SHALL decrement by 1 on accept-only, increment by 1 on pop-only, and stay unchanged when both occur in the same cycle.
REQ-024 Invariant: credits + in-flight ops + FIFO occupancy == DEPTH at every cycle boundary.
REQ-025 Push SHALL occur when unit_rvalid_i is high, storing {rdata, rflags, rID} at the write pointer.
REQ-026 core_rvalid_o SHALL equal FIFO not-empty, with fields driven from the head entry; a push becomes visible the cycle after unit_rvalid_i (no same-cycle bypass).
REQ-027 Head fields SHALL remain stable while core_rvalid_o is high and core_rready_i is low.
REQ-028 Push and pop in the same cycle SHALL both take effect, including when full; occupancy is then unchanged.
REQ-029 Push when full without a pop SHALL drop the entry, leave state unchanged and set overflow_o until reset.
REQ-030 Pop when empty SHALL be impossible, because core_rvalid_o is low.
REQ-031 Pointers SHALL be clog2(DEPTH) bits wrapping modulo DEPTH; full/empty SHALL be derived from an occupancy counter of clog2(DEPTH)+1 bits.
REQ-032 The response order SHALL equal the unit completion order; no reordering by ID.

Reset
REQ-033 On rst_n low, credits SHALL be DEPTH, pointers and occupancy 0, and overflow_o 0.
REQ-034 During and after reset, core_rvalid_o SHALL be 0, core_rdata_o/core_rflags_o/core_rID_o SHALL be 0, and unit_req_o/core_gnt_o SHALL follow REQ-021 with full credits.
REQ-035 Reset mid-operation SHALL discard buffered entries and in-flight credit accounting; the unit is reset by the same rst_n.

Structure
REQ-036 The package fp_divsqrt_pkg SHALL contain the response struct typedef (rdata, rflags, rID) and the default width constants.
REQ-037 Storage and pointers SHALL live in one sub-module, fp_divsqrt_resp_mem (push/pop, full/empty, head output); credit logic stays in the top.

Verification
REQ-038 After reset, hold core_rready_i=0 and issue 3 requests with unit_gnt_i=1 -> 2 grants, the 3rd stalls, credits_o=0, unit_req_o=0.
REQ-039 Unit returns rdata=32'h3F80_0000 / rID=5, then 32'h4000_0000 / rID=6 -> core_rvalid_o high the next cycle; pops return rID 5 then 6, and credits_o returns to 2.
REQ-040 With credits_o=0 and the FIFO full, assert unit_rvalid_i and core_rready_i in the same cycle -> occupancy stays 2, order is preserved, overflow_o=0.
REQ-041 Force unit_rvalid_i while full with core_rready_i=0 -> overflow_o=1 sticky, and the head stays the rID from before.
REQ-042 Accept and pop in the same cycle with credits_o=1 -> credits_o stays 1.
REQ-043 Assert rst_n low with 2 entries buffered -> core_rvalid_o=0 and credits_o=2 immediately (asynchronous), overflow_o=0.
